// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: streams a WIDTH-bit operand pair LSB-first through a 1-bit ALU slice.
// Optional abort of the in-flight operation is enabled by defining ALU_SERIAL_ABORT_EN.
module alu_serial_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             abort,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [2:0]       slice_sel,
    input  logic             slice_out,
    input  logic             slice_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_ovf
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [CW-1:0]    cnt;

    logic             last_bit;
    logic             is_slt;
    logic             is_arith;
    logic             ovf_msb;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] final_res;
    logic             abort_hit;

`ifdef ALU_SERIAL_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    logic unused_abort;
    assign abort_hit    = 1'b0;
    assign unused_abort = abort;
`endif

    // The shift-register LSBs are zero outside RUN, so they drive the slice directly.
    assign slice_a = a_sr[0];
    assign slice_b = b_sr[0];

    always_comb begin
        last_bit  = (cnt == CW'(WIDTH - 1));
        is_slt    = (slice_sel == 3'b011);
        is_arith  = !slice_sel[2] && (slice_sel != 3'b010);
        ovf_msb   = slice_cin ^ slice_cout;
        shifted   = {slice_out, out_result[WIDTH-1:1]};
        final_res = shifted;
        if (is_slt) begin
            final_res = {{(WIDTH-1){1'b0}}, slice_out ^ ovf_msb};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            a_sr       <= '0;
            b_sr       <= '0;
            cnt        <= '0;
            slice_cin  <= 1'b0;
            slice_sel  <= 3'b000;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b0;
            out_carry  <= 1'b0;
            out_ovf    <= 1'b0;
        end else if (abort_hit) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            a_sr       <= '0;
            b_sr       <= '0;
            cnt        <= '0;
            slice_cin  <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b0;
            out_carry  <= 1'b0;
            out_ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr      <= in_a;
                        b_sr      <= in_b;
                        slice_sel <= in_op;
                        cnt       <= '0;
                        // SUB and SLT add the inverted B with a carry-in of one.
                        slice_cin <= !in_op[2] && in_op[0];
                        in_ready  <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    cnt  <= cnt + CW'(1);
                    if (last_bit) begin
                        out_result <= final_res;
                        out_zero   <= (final_res == '0);
                        out_carry  <= is_arith && !is_slt && slice_cout;
                        out_ovf    <= is_arith && !is_slt && ovf_msb;
                        out_valid  <= 1'b1;
                        slice_cin  <= 1'b0;
                        state      <= DONE;
                    end else begin
                        out_result <= shifted;
                        slice_cin  <= slice_cout;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed-vector bench for alu_serial_seq with a behavioural 1-bit ALU slice.
module tb_alu_serial_seq;

    localparam int unsigned W = 32;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [2:0]    in_op;
    logic          abort;
    logic          slice_a;
    logic          slice_b;
    logic          slice_cin;
    logic [2:0]    slice_sel;
    logic          slice_out;
    logic          slice_cout;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic          out_zero;
    logic          out_carry;
    logic          out_ovf;

    int checks = 0;
    int errors = 0;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .abort      (abort),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_sel  (slice_sel),
        .slice_out  (slice_out),
        .slice_cout (slice_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_carry  (out_carry),
        .out_ovf    (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slice model; carry-out is always a full-adder carry so logic ops must ignore it.
    logic bx;
    always_comb begin
        bx         = slice_b ^ ((slice_sel == 3'b001) || (slice_sel == 3'b011));
        slice_cout = (slice_a & bx) | (slice_a & slice_cin) | (bx & slice_cin);
        case (slice_sel)
            3'b010:  slice_out = slice_a ^ slice_b;
            3'b100:  slice_out = slice_a & slice_b;
            3'b101:  slice_out = ~(slice_a & slice_b);
            3'b110:  slice_out = ~(slice_a | slice_b);
            3'b111:  slice_out = slice_a | slice_b;
            default: slice_out = slice_a ^ bx ^ slice_cin;
        endcase
    end

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         v;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        check({tag, "_in_ready"}, W'(in_ready), W'(1));
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        step();
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
    endtask

    task automatic check_done(input string tag, input vec_t v);
        check({tag, "_valid"}, W'(out_valid), W'(1));
        check({tag, "_result"}, out_result, v.res);
        check({tag, "_zero"}, W'(out_zero), W'(v.z));
        check({tag, "_carry"}, W'(out_carry), W'(v.c));
        check({tag, "_ovf"}, W'(out_ovf), W'(v.v));
        check({tag, "_idle_slice"}, W'({slice_a, slice_b, slice_cin}), W'(0));
    endtask

    task automatic ack(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_ack_valid"}, W'(out_valid), W'(0));
        check({tag, "_ack_ready"}, W'(in_ready), W'(1));
    endtask

    // Full operation: bit i must be on the slice i cycles after the accept edge, valid after WIDTH edges.
    task automatic run_vec(input string tag, input vec_t v);
        logic bad;
        bad = 1'b0;
        start_op(tag, v.op, v.a, v.b);
        check({tag, "_sel"}, W'(slice_sel), W'(v.op));
        check({tag, "_cin0"}, W'(slice_cin), W'((v.op == 3'b001) || (v.op == 3'b011)));
        for (int i = 0; i < int'(W); i++) begin
            if (slice_a !== v.a[i] || slice_b !== v.b[i] || out_valid !== 1'b0 || in_ready !== 1'b0)
                bad = 1'b1;
            step();
        end
        check({tag, "_stream"}, W'(bad), W'(0));
        check_done(tag, v);
        ack(tag);
    endtask

    initial begin
        vec_t bp;
        logic bad;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = 3'b000;
        abort     = 1'b0;
        out_ready = 1'b0;

        vecs[0]  = '{3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{3'b001, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'b001, 32'h00000007, 32'h00000005, 32'h00000002, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{3'b011, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'b011, 32'h00000001, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{3'b010, 32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'b100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{3'b110, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{3'b001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{3'b001, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{3'b011, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{3'b011, 32'h00000007, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{3'b000, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{3'b111, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{3'b000, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1};

        repeat (3) step();
        rst_n = 1'b1;
        check("rst_ready", W'(in_ready), W'(1));
        check("rst_valid", W'(out_valid), W'(0));
        check("rst_result", out_result, W'(0));
        check("rst_flags", W'({out_zero, out_carry, out_ovf}), W'(0));
        check("rst_slice", W'({slice_a, slice_b, slice_cin, slice_sel}), W'(0));

        for (int n = 0; n < 18; n++) begin
            run_vec($sformatf("vec%0d", n), vecs[n]);
        end

        // Backpressure: result held for 10 cycles while new offers are ignored.
        bp  = '{3'b000, 32'h00000003, 32'h00000004, 32'h00000007, 1'b0, 1'b0, 1'b0};
        bad = 1'b0;
        start_op("bp", bp.op, bp.a, bp.b);
        repeat (W) step();
        check_done("bp", bp);
        in_valid = 1'b1;
        in_a     = 32'hDEADBEEF;
        in_b     = 32'h0BADF00D;
        in_op    = 3'b111;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== 32'h7 ||
                {out_zero, out_carry, out_ovf} !== 3'b000 || slice_sel !== 3'b000)
                bad = 1'b1;
        end
        check("bp_hold", W'(bad), W'(0));
        in_valid = 1'b0;
        ack("bp");

        // Synchronous reset at bit 10 returns to IDLE with cleared outputs.
        start_op("rst_mid", 3'b111, 32'hFFFFFFFF, 32'h0);
        repeat (10) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_mid_ready", W'(in_ready), W'(1));
        check("rst_mid_valid", W'(out_valid), W'(0));
        check("rst_mid_result", out_result, W'(0));
        check("rst_mid_slice", W'({slice_a, slice_b, slice_cin, slice_sel}), W'(0));
        run_vec("after_rst", vecs[3]);

        // Abort at bit 10.
        start_op("abort", 3'b000, 32'h7FFFFFFF, 32'h00000001);
        repeat (10) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
`ifdef ALU_SERIAL_ABORT_EN
        check("abort_ready", W'(in_ready), W'(1));
        check("abort_valid", W'(out_valid), W'(0));
        check("abort_result", out_result, W'(0));
        check("abort_slice", W'({slice_a, slice_b, slice_cin}), W'(0));
`else
        repeat (W - 11) step();
        check_done("abort_ign", vecs[1]);
        ack("abort_ign");
`endif
        run_vec("after_abort", vecs[11]);

        // Abort while idle never disturbs the next accept.
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("idle_abort_ready", W'(in_ready), W'(1));
        run_vec("after_idle_abort", vecs[13]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
